// File: rtl/inst_fetch_pkg.sv
// Shared bus widths and constants for the instruction-fetch stage.
// Every fetch-stage file imports this package.
package inst_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int EntryW      = InstAddrBus + InstBus;

    localparam logic [InstBus-1:0]     ZeroWord     = '0;
    localparam logic [InstAddrBus-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] PcStep       = 32'd4;

    function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Synchronous FIFO with flush that holds fetched {pc, inst} entries.
// The head entry is read combinationally. BUF_DEPTH must be a power of two.
module fetch_buf #(
    parameter  int BUF_DEPTH = 2,
    parameter  int DATA_W    = 64,
    localparam int AW        = $clog2(BUF_DEPTH),
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [BUF_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (i_pop && !i_push) r_count <= r_count - 1'b1;
        end
    end

    // A push into a full buffer always pairs with a pop. The old head is read
    // before this edge, so the write can safely reuse its slot.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(BUF_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM, and buffers
// {pc, inst} pairs for decode. Execute-stage redirects flush the buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int                     BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce,
    output logic [InstAddrBus-1:0] rom_raddr,
    input  logic [InstBus-1:0]     rom_rdata,
    input  logic                   redirect_valid,
    input  logic [InstAddrBus-1:0] redirect_pc,
    output logic                   id_valid,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    input  logic                   id_ready
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [InstAddrBus-1:0] r_pc;
    logic                   w_pop;
    logic                   w_fetch;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic [EntryW-1:0]      w_head;

    // A redirect blocks both the pop and the fetch. id_ready therefore reaches
    // rom_ce combinationally when the buffer is full.
    assign w_pop   = ~w_empty & id_ready & ~redirect_valid;
    assign w_fetch = ~rst & ~redirect_valid & ((w_count < CW'(BUF_DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (rst)                 r_pc <= RESET_PC;
        else if (redirect_valid) r_pc <= align_pc(redirect_pc);
        else if (w_fetch)        r_pc <= r_pc + PcStep;
    end

    fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .DATA_W    (EntryW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_din   ({r_pc, rom_rdata}),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) assert (!(w_fetch && w_full && !w_pop));
    end

    assign rom_ce    = w_fetch;
    assign rom_raddr = r_pc;
    assign id_valid  = ~w_empty;
    assign id_pc     = w_empty ? ZeroWord : w_head[EntryW-1:InstBus];
    assign id_inst   = w_empty ? ZeroWord : w_head[InstBus-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a hand-derived vector table, then randomized traffic
// compared against a queue-based model of the fetch buffer.
module tb_inst_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, rom_ce, redirect_valid, id_valid, id_ready;
    logic [31:0] rom_raddr, rom_rdata, redirect_pc, id_pc, id_inst;
    logic [31:0] salt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // ROM contents: word i holds i, optionally XORed with a salt.
    assign rom_rdata = (rom_raddr >> 2) ^ salt;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce         (rom_ce),
        .rom_raddr      (rom_raddr),
        .rom_rdata      (rom_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_ready       (id_ready)
    );

    typedef struct {
        logic        rst, rv, rdy;
        logic [31:0] rpc;
        logic        ce, vld;
        logic [31:0] raddr, pc, inst;
    } vec_t;

    vec_t        tbl [29];
    logic [63:0] mq [$];
    logic [31:0] mpc;

    function automatic vec_t mk(input logic [31:0] r, rv, rp, rd, ce, ra, v, p, ins);
        vec_t t;
        t.rst = r[0];  t.rv = rv[0]; t.rpc = rp; t.rdy = rd[0];
        t.ce  = ce[0]; t.raddr = ra; t.vld = v[0]; t.pc = p; t.inst = ins;
        return t;
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
        rst = r; redirect_valid = rv; redirect_pc = rp; id_ready = rd;
        #2;
    endtask

    task automatic check_all(input string tag, input logic ce, input logic [31:0] ra,
                             input logic v, input logic [31:0] p, input logic [31:0] ins);
        chk({tag, ".rom_ce"},    {31'b0, rom_ce},   {31'b0, ce});
        chk({tag, ".rom_raddr"}, rom_raddr,         ra);
        chk({tag, ".id_valid"},  {31'b0, id_valid}, {31'b0, v});
        chk({tag, ".id_pc"},     id_pc,             p);
        chk({tag, ".id_inst"},   id_inst,           ins);
    endtask

    task automatic check_model(input string tag);
        logic        v;
        logic [31:0] p, ins;
        logic        ce;
        v   = (mq.size() > 0);
        p   = v ? mq[0][63:32] : 32'h0;
        ins = v ? mq[0][31:0]  : 32'h0;
        ce  = !rst && !redirect_valid && ((mq.size() < DEPTH) || (v && id_ready));
        check_all(tag, ce, mpc, v, p, ins);
    endtask

    // Decisions use the pre-edge inputs and model state; they are applied after the edge.
    task automatic advance();
        logic        v, pop, fetch;
        logic [63:0] ent;
        v     = (mq.size() > 0);
        pop   = v && id_ready && !redirect_valid;
        fetch = !rst && !redirect_valid && ((mq.size() < DEPTH) || pop);
        ent   = {mpc, rom_word(mpc)};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            mpc = RPC;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (fetch) begin
                mq.push_back(ent);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    initial begin
        salt = 32'h0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

        //         rst rv rpc            rdy  ce raddr          vld pc             inst
        tbl[0]  = mk(1, 0, 0,             0,   0, 0,             0, 0,             0);
        tbl[1]  = mk(0, 0, 0,             0,   1, 0,             0, 0,             0);
        tbl[2]  = mk(0, 0, 0,             0,   1, 4,             1, 0,             0);
        tbl[3]  = mk(0, 0, 0,             0,   0, 8,             1, 0,             0);
        tbl[4]  = mk(0, 0, 0,             0,   0, 8,             1, 0,             0);
        tbl[5]  = mk(0, 0, 0,             0,   0, 8,             1, 0,             0);
        tbl[6]  = mk(0, 0, 0,             1,   1, 8,             1, 0,             0);
        tbl[7]  = mk(0, 0, 0,             1,   1, 'hC,           1, 4,             1);
        tbl[8]  = mk(0, 0, 0,             1,   1, 'h10,          1, 8,             2);
        tbl[9]  = mk(0, 0, 0,             1,   1, 'h14,          1, 'hC,           3);
        tbl[10] = mk(0, 0, 0,             0,   0, 'h18,          1, 'h10,          4);
        tbl[11] = mk(0, 1, 'h103,         0,   0, 'h18,          1, 'h10,          4);
        tbl[12] = mk(0, 0, 0,             0,   1, 'h100,         0, 0,             0);
        tbl[13] = mk(0, 0, 0,             1,   1, 'h104,         1, 'h100,         'h40);
        tbl[14] = mk(0, 1, 'h200,         1,   0, 'h108,         1, 'h104,         'h41);
        tbl[15] = mk(0, 0, 0,             1,   1, 'h200,         0, 0,             0);
        tbl[16] = mk(0, 0, 0,             1,   1, 'h204,         1, 'h200,         'h80);
        tbl[17] = mk(0, 1, 'h300,         1,   0, 'h208,         1, 'h204,         'h81);
        tbl[18] = mk(0, 1, 'h40F,         1,   0, 'h300,         0, 0,             0);
        tbl[19] = mk(0, 0, 0,             1,   1, 'h40C,         0, 0,             0);
        tbl[20] = mk(0, 0, 0,             1,   1, 'h410,         1, 'h40C,         'h103);
        tbl[21] = mk(0, 1, 'hFFFF_FFFE,   1,   0, 'h414,         1, 'h410,         'h104);
        tbl[22] = mk(0, 0, 0,             1,   1, 'hFFFF_FFFC,   0, 0,             0);
        tbl[23] = mk(0, 0, 0,             1,   1, 0,             1, 'hFFFF_FFFC,   'h3FFF_FFFF);
        tbl[24] = mk(0, 0, 0,             1,   1, 4,             1, 0,             0);
        tbl[25] = mk(0, 0, 0,             0,   1, 8,             1, 4,             1);
        tbl[26] = mk(1, 0, 0,             0,   0, 'hC,           1, 4,             1);
        tbl[27] = mk(0, 0, 0,             0,   1, 0,             0, 0,             0);
        tbl[28] = mk(0, 0, 0,             1,   1, 4,             1, 0,             0);

        @(posedge clk);
        @(posedge clk);
        #1;
        mq.delete();
        mpc = RPC;

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            check_all($sformatf("tbl%0d", i), tbl[i].ce, tbl[i].raddr,
                      tbl[i].vld, tbl[i].pc, tbl[i].inst);
            advance();
        end

        // Toggle id_ready every cycle: entries must be neither dropped nor duplicated.
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b0, 32'h0, i[0]);
            check_model($sformatf("toggle%0d", i));
            advance();
        end

        // Hold the buffer full for several cycles, then release it.
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 1'b0, 32'h0, (i >= 6));
            check_model($sformatf("stall%0d", i));
            advance();
        end

        // Randomized traffic; the ready probability changes every 250 cycles.
        salt = $urandom;
        for (int i = 0; i < 3000; i++) begin
            logic        r, rv, rd;
            logic [31:0] rp;
            int          rdy_pct;
            rdy_pct = 20 + 25 * ((i / 250) % 4);
            r  = ($urandom_range(0, 59) == 0);
            rv = ($urandom_range(0, 11) == 0);
            rp = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
            rd = ($urandom_range(0, 99) < rdy_pct);
            apply(r, rv, rp, rd);
            check_model($sformatf("rand%0d", i));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
